// File: rtl/apb_bridge_pkg.sv
// Shared types and response codes for the AXI4-Lite to APB bridge.
// The transactor and the APB master sequencer both import this package.
package apb_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Completion code for a transfer that ended with pready.
  function automatic logic [1:0] apb_resp(input logic slverr);
    return slverr ? RESP_SLVERR : RESP_OKAY;
  endfunction

endpackage

// File: rtl/apb_req_arbiter.sv
// Two-requester round-robin grant between the write and read request channels.
// The grant is combinational; the fairness bit flips only on a contested grant.
module apb_req_arbiter
  import apb_bridge_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic wr_valid,
  input  logic rd_valid,
  output logic gnt_wr,
  output logic gnt_rd
);

  logic prio_rd;

  always_comb begin
    gnt_wr = 1'b0;
    gnt_rd = 1'b0;
    if (enable) begin
      if (wr_valid && rd_valid) begin
        gnt_wr = ~prio_rd;
        gnt_rd = prio_rd;
      end else begin
        gnt_wr = wr_valid;
        gnt_rd = rd_valid;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      prio_rd <= 1'b0;
    end else if (enable && wr_valid && rd_valid) begin
      prio_rd <= ~prio_rd;
    end
  end

endmodule

// File: rtl/apb_master_sequencer.sv
// APB4 master: takes one granted write or read request, runs SETUP/ACCESS with
// a bounded wait for pready, and returns the completion on a valid/ready channel.
module apb_master_sequencer
  import apb_bridge_pkg::*;
#(
  parameter int dataWidth = 32,
  parameter int addrWidth = 32,
  parameter int TIMEOUT   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic [addrWidth-1:0]   wr_addr,
  input  logic [2:0]             wr_prot,
  input  logic [dataWidth-1:0]   wr_data,
  input  logic [dataWidth/8-1:0] wr_strb,
  input  logic                   rd_valid,
  output logic                   rd_ready,
  input  logic [addrWidth-1:0]   rd_addr,
  input  logic [2:0]             rd_prot,
  output logic                   b_valid,
  input  logic                   b_ready,
  output logic [1:0]             b_resp,
  output logic                   r_valid,
  input  logic                   r_ready,
  output logic [dataWidth-1:0]   r_data,
  output logic [1:0]             r_resp,
  output logic                   psel,
  output logic                   penable,
  output logic                   pwrite,
  output logic [addrWidth-1:0]   paddr,
  output logic [2:0]             pprot,
  output logic [dataWidth-1:0]   pwdata,
  output logic [dataWidth/8-1:0] pstrb,
  input  logic [dataWidth-1:0]   prdata,
  input  logic                   pready,
  input  logic                   pslverr
);

  localparam int CntWidth = $clog2(TIMEOUT + 1);
  localparam logic [CntWidth-1:0] TimeoutCnt = CntWidth'(TIMEOUT);

  apb_state_e          state;
  logic [CntWidth-1:0] timer;
  logic                arb_enable;
  logic                gnt_wr;
  logic                gnt_rd;

  // Gated by rst so the ready outputs are also 0 while reset is held.
  assign arb_enable = (state == IDLE) && rst;
  assign wr_ready   = gnt_wr;
  assign rd_ready   = gnt_rd;

  apb_req_arbiter u_arbiter (
    .clk      (clk),
    .rst      (rst),
    .enable   (arb_enable),
    .wr_valid (wr_valid),
    .rd_valid (rd_valid),
    .gnt_wr   (gnt_wr),
    .gnt_rd   (gnt_rd)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      timer   <= '0;
      psel    <= 1'b0;
      penable <= 1'b0;
      pwrite  <= 1'b0;
      paddr   <= '0;
      pprot   <= '0;
      pwdata  <= '0;
      pstrb   <= '0;
      b_valid <= 1'b0;
      b_resp  <= '0;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_resp  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_wr) begin
            pwrite <= 1'b1;
            paddr  <= wr_addr;
            pprot  <= wr_prot;
            pwdata <= wr_data;
            pstrb  <= wr_strb;
            psel   <= 1'b1;
            state  <= SETUP;
          end else if (gnt_rd) begin
            pwrite <= 1'b0;
            paddr  <= rd_addr;
            pprot  <= rd_prot;
            pwdata <= '0;
            pstrb  <= '0;
            psel   <= 1'b1;
            state  <= SETUP;
          end
        end

        SETUP: begin
          penable <= 1'b1;
          timer   <= CntWidth'(1);
          state   <= ACCESS;
        end

        // pslverr only means something alongside pready; a silent slave is
        // cut off after TIMEOUT access cycles and reported as DECERR.
        ACCESS: begin
          if (pready) begin
            psel    <= 1'b0;
            penable <= 1'b0;
            state   <= RESP;
            if (pwrite) begin
              b_valid <= 1'b1;
              b_resp  <= apb_resp(pslverr);
            end else begin
              r_valid <= 1'b1;
              r_resp  <= apb_resp(pslverr);
              r_data  <= prdata;
            end
          end else if (timer == TimeoutCnt) begin
            psel    <= 1'b0;
            penable <= 1'b0;
            state   <= RESP;
            if (pwrite) begin
              b_valid <= 1'b1;
              b_resp  <= RESP_DECERR;
            end else begin
              r_valid <= 1'b1;
              r_resp  <= RESP_DECERR;
              r_data  <= '0;
            end
          end else begin
            timer <= timer + CntWidth'(1);
          end
        end

        RESP: begin
          if (b_valid && b_ready) begin
            b_valid <= 1'b0;
            state   <= IDLE;
          end
          if (r_valid && r_ready) begin
            r_valid <= 1'b0;
            state   <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/apb_master_sequencer.md
Name: apb_master_sequencer

Overview:
- Downstream stage of the AXI4-Lite transactor in the AXI4-Lite→APB bridge.
- Accepts one latched write or read request from the transactor side and runs the APB SETUP/ACCESS sequence (APB4: pprot, pstrb).
- Returns the completion (bresp, or rdata + rresp) through a valid/ready response channel.
- Single outstanding transfer; one bit of round-robin fairness between write and read.

Parameters:
- dataWidth, 32, APB/AXI data width; multiple of 8.
- addrWidth, 32, address width.
- TIMEOUT, 16, max ACCESS cycles waiting for pready before forced termination; must be ≥2.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-low.
- wr_valid  in  1  write request valid.
- wr_ready  out  1  write request accepted.
- wr_addr  in  addrWidth  write address.
- wr_prot  in  3  write protection.
- wr_data  in  dataWidth  write data.
- wr_strb  in  dataWidth/8  write strobes.
- rd_valid  in  1  read request valid.
- rd_ready  out  1  read request accepted.
- rd_addr  in  addrWidth  read address.
- rd_prot  in  3  read protection.
- b_valid  out  1  write response valid.
- b_ready  in  1  write response taken.
- b_resp  out  2  write response code.
- r_valid  out  1  read response valid.
- r_ready  in  1  read response taken.
- r_data  out  dataWidth  read data.
- r_resp  out  2  read response code.
- psel, penable, pwrite  out  1 each  APB control.
- paddr  out  addrWidth  APB address.
- pprot  out  3  APB protection.
- pwdata  out  dataWidth  APB write data.
- pstrb  out  dataWidth/8  APB strobes; all-zero on reads.
- prdata  in  dataWidth  APB read data.
- pready  in  1  APB ready.
- pslverr  in  1  APB slave error.

Behaviour:
- Reset (rst=0 at posedge): state=IDLE, every output 0 (no X), fairness bit = write-first. Reset mid-transfer drops psel/penable next edge; the transfer is abandoned and no response is issued.
- States: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - wr_ready/rd_ready are combinational; only one is high, and only while in IDLE.
  - If only one of wr_valid/rd_valid is set, grant it.
  - If both are set, grant the side selected by the fairness bit, then toggle the bit.
  - On grant: capture addr/prot/data/strb and the direction; go to SETUP.
- SETUP (exactly 1 cycle): psel=1, penable=0; paddr/pwrite/pprot/pwdata/pstrb hold the captured values. Next state: ACCESS.
- ACCESS: psel=1, penable=1; all APB outputs stable. Timeout counter starts at 1 on the first ACCESS cycle.
  - pready=1: sample prdata and pslverr. resp = pslverr ? 2'b10 (SLVERR) : 2'b00 (OKAY). Go to RESP.
  - pready=0 and counter==TIMEOUT: resp=2'b11 (DECERR), r_data=0. Go to RESP.
  - Otherwise: increment counter.
- RESP:
  - psel=penable=0.
  - Write transfer: b_valid=1. Read transfer: r_valid=1 with r_data = sampled prdata.
  - Response outputs stay stable until the matching ready is high at a clock edge; then clear valid and go to IDLE.
  - A new request is accepted no earlier than the cycle after the response handshake.
- Latency: request handshake at edge N → SETUP in cycle N+1 → ACCESS in N+2 → with zero-wait pready, response valid in N+3.
- pready asserted during SETUP is ignored.
- pslverr is ignored unless pready=1 in ACCESS.
- b_resp/r_resp/r_data hold their last value after the handshake. Only valid is cleared.

Decomposition:
- Package apb_bridge_pkg:
  - State enum apb_state_e {IDLE, SETUP, ACCESS, RESP}.
  - Response constants RESP_OKAY=2'b00, RESP_SLVERR=2'b10, RESP_DECERR=2'b11.
  - Shared with the transactor.
- One sub-module: apb_req_arbiter. Contains the two-requester round-robin grant and the fairness bit; combinational grant plus one flop.

Test Plan:
- Write 0x0000_0010 / 0xDEAD_BEEF, strb 4'hF, pready=1 in the first ACCESS cycle → pwrite=1, pstrb=4'hF; b_valid at N+3 with b_resp=00; psel high for exactly 2 cycles.
- Read 0x0000_0020, prdata=0x1234_5678, pready after 3 wait cycles → penable high for 4 cycles; r_data=0x1234_5678, r_resp=00; pstrb=0.
- wr_valid and rd_valid both held high for 4 transfers from reset → grant order W,R,W,R.
- Write with pslverr=1 together with pready → b_resp=10. Hold b_ready=0 for 5 cycles → b_valid and b_resp stay stable; wr_ready stays 0 throughout.
- Read with pready stuck low, TIMEOUT=16 → ACCESS lasts exactly 16 cycles; r_resp=11, r_data=0; psel drops the next cycle.
- Assert rst=0 during ACCESS → next edge all outputs 0, state IDLE, no b_valid; a following write completes normally.
